// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, alignment check, load extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            size,
    input  logic [1:0]            addr_lo,
    input  logic [31:0]           wdata,
    input  logic [31:0]           rdata_word,
    output logic [WORD_BYTES-1:0] be,
    output logic [31:0]           wdata_rep,
    output logic                  misaligned,
    output logic [31:0]           rdata_ext
);

    logic        is_b;
    logic        is_h;
    logic        is_signed;
    logic [31:0] lane;

    // Decode the size; anything that is not a byte or half access behaves as a word.
    always_comb begin
        is_b       = (size == SZ_B) || (size == SZ_BU);
        is_h       = (size == SZ_H) || (size == SZ_HU);
        is_signed  = (size == SZ_B) || (size == SZ_H);
        // Shifting the word right by the byte offset puts the addressed lane at bit 0;
        // aligned halves only ever use offsets 0 and 2.
        lane       = rdata_word >> {addr_lo, 3'b000};
        be         = '1;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        rdata_ext  = rdata_word;
        if (is_b) begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = is_signed ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
        end else if (is_h) begin
            be         = 4'b0011 << addr_lo;
            wdata_rep  = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
            rdata_ext  = is_signed ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
        end else begin
            misaligned = (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory port: one load/store per request, req/ready handshake with timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        timeout_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    lsu_state_t  state, state_nxt;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  cnt;

    logic        accept, fin_ok, fin_to;
    logic [2:0]  al_size;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis;

    // One aligner serves both phases: request inputs in IDLE, latched values afterwards.
    assign al_size = (state == ST_IDLE) ? size      : size_q;
    assign al_lo   = (state == ST_IDLE) ? addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .size       (al_size),
        .addr_lo    (al_lo),
        .wdata      (wdata),
        .rdata_word (m_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .misaligned (al_mis),
        .rdata_ext  (al_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and transition strobes; m_ready wins over an expiring counter.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = al_mis ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (m_ready) begin
                    fin_ok    = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == TO_LIMIT) begin
                    fin_to    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and latched request fields, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_be        <= '0;
            m_wdata     <= '0;
            rdata       <= '0;
            misaligned  <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            addr_lo_q   <= '0;
        end else begin
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state_nxt == ST_DONE);
            m_req <= (state_nxt == ST_ACCESS);
            if (accept) begin
                we_q        <= req_we;
                size_q      <= size;
                addr_lo_q   <= addr[1:0];
                m_addr      <= {addr[31:2], 2'b00};
                m_be        <= req_we ? al_be : 4'b1111;
                m_wdata     <= al_wdata;
                m_we        <= req_we && !al_mis;
                misaligned  <= al_mis;
                timeout_err <= 1'b0;
                cnt         <= '0;
                if (al_mis) rdata <= '0;
            end
            if (state == ST_ACCESS && state_nxt == ST_ACCESS && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
            if (fin_ok) begin
                m_we <= 1'b0;
                if (!we_q) rdata <= al_rdata;
            end
            if (fin_to) begin
                m_we        <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations (TIMEOUT=4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, misaligned, timeout_err;
    logic [31:0] rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ready;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .size(size), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misaligned(misaligned), .timeout_err(timeout_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in the first cycle after accept.
    task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        size      = sz;
        addr      = a;
        wdata     = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mreq"}, 32'(m_req), 0);
        chk({tag, "_mwe"}, 32'(m_we), 0);
        chk({tag, "_mbe"}, 32'(m_be), 0);
        chk({tag, "_maddr"}, m_addr, 0);
        chk({tag, "_mwdata"}, m_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mis"}, 32'(misaligned), 0);
        chk({tag, "_to"}, 32'(timeout_err), 0);
    endtask

    initial begin
        int n_req, n_done;
        bit got_done;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; size = 3'b000;
        addr = '0; wdata = '0; m_ready = 1'b0; m_rdata = '0;
        step(); step();
        reset = 1'b0;
        chk_all_zero("rst");

        // sb 0x103: lane 3, replicated data, done two cycles after accept
        do_req(1'b1, 3'b000, 32'h103, 32'hAB);
        chk("sb_mreq", 32'(m_req), 1);
        chk("sb_mwe", 32'(m_we), 1);
        chk("sb_be", 32'(m_be), 32'b1000);
        chk("sb_wdata", m_wdata, 32'hABABABAB);
        chk("sb_addr", m_addr, 32'h100);
        chk("sb_busy", 32'(busy), 1);
        chk("sb_done_early", 32'(done), 0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("sb_done", 32'(done), 1);
        chk("sb_mreq_off", 32'(m_req), 0);
        chk("sb_busy_done", 32'(busy), 1);
        step();
        chk("sb_done_pulse", 32'(done), 0);
        chk("sb_idle_busy", 32'(busy), 0);

        // sh 0x102: upper half enables, half replicated
        do_req(1'b1, 3'b001, 32'h102, 32'h5678);
        chk("sh_be", 32'(m_be), 32'b1100);
        chk("sh_wdata", m_wdata, 32'h56785678);
        m_ready = 1'b1; step(); m_ready = 1'b0; step();

        // lb / lbu 0x102 from 0x0080FF00
        m_rdata = 32'h0080FF00;
        do_req(1'b0, 3'b000, 32'h102, 32'h0);
        chk("lb_be", 32'(m_be), 32'b1111);
        chk("lb_mwe", 32'(m_we), 0);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        step();
        do_req(1'b0, 3'b100, 32'h102, 32'h0);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("lbu_rdata", rdata, 32'h00000080);
        step();

        // lw timeout: m_req exactly TIMEOUT+1 = 5 cycles, rdata untouched
        do_req(1'b0, 3'b010, 32'h200, 32'h0);
        n_req = 0; got_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got_done = 1; break; end
            if (m_req) n_req++;
            step();
        end
        chk("to_reached", 32'(got_done), 1);
        chk("to_mreq_cycles", n_req, 5);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_rdata_held", rdata, 32'h00000080);
        step();

        // lh 0x101 misaligned: done next cycle, no memory request, rdata cleared
        do_req(1'b0, 3'b001, 32'h101, 32'h0);
        chk("mis_done", 32'(done), 1);
        chk("mis_flag", 32'(misaligned), 1);
        chk("mis_mreq", 32'(m_req), 0);
        chk("mis_rdata", rdata, 0);
        chk("mis_to_clr", 32'(timeout_err), 0);
        step();
        chk("mis_mreq2", 32'(m_req), 0);

        // m_ready in the 5th request cycle (counter at limit) wins over timeout
        m_rdata = 32'hCAFEF00D;
        do_req(1'b0, 3'b010, 32'h204, 32'h0);
        chk("lim_mis_clr", 32'(misaligned), 0);
        step(); step(); step(); step();
        chk("lim_mreq5", 32'(m_req), 1);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("lim_done", 32'(done), 1);
        chk("lim_to", 32'(timeout_err), 0);
        chk("lim_rdata", rdata, 32'hCAFEF00D);
        step();

        // lhu 0x202 with 3 wait cycles
        m_rdata = 32'hBEEF1234;
        do_req(1'b0, 3'b101, 32'h202, 32'h0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) n_done++;
            step();
        end
        chk("lhu_no_early_done", n_done, 0);
        chk("lhu_mreq", 32'(m_req), 1);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("lhu_done", 32'(done), 1);
        chk("lhu_rdata", rdata, 32'h0000BEEF);
        step();

        // reset during a wait: outputs cleared, no done afterwards
        do_req(1'b1, 3'b010, 32'h300, 32'h11223344);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk_all_zero("midrst");
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || m_req) n_done++;
            step();
        end
        chk("midrst_quiet", n_done, 0);

        // m_ready with no request outstanding is ignored
        m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("idle_ready_done", 32'(done), 0);

        // req_valid pulsed during ACCESS: ignored, exactly one done
        do_req(1'b1, 3'b010, 32'h010, 32'h12345678);
        req_valid = 1'b1; addr = 32'h400; step(); req_valid = 1'b0;
        chk("ign_addr", m_addr, 32'h010);
        m_ready = 1'b1; step(); m_ready = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            step();
        end
        chk("ign_one_done", n_done, 1);
        chk("ign_wdata", m_wdata, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
